// File: rtl/rr_decoder_arbiter_pkg.sv
// rtl/rr_decoder_arbiter_pkg.sv - shared types and helpers for the round-robin decoder arbiter
package rr_decoder_arbiter_pkg;

    localparam int NREQ  = 8;
    localparam int IDX_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } arb_state_e;

    function automatic logic [NREQ-1:0] onehot8(input logic [IDX_W-1:0] idx);
        return NREQ'(1) << idx;
    endfunction

endpackage

// File: rtl/rr_pick8.sv
// rtl/rr_pick8.sv - combinational rotating-priority picker, search starts at ptr+1
module rr_pick8
    import rr_decoder_arbiter_pkg::*;
(
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    logic [NREQ-1:0]  rot;
    logic [IDX_W-1:0] off;

    // rot[0] is the requester just after ptr, so a fixed lowest-first scan is round-robin
    always_comb begin
        rot = '0;
        for (int i = 0; i < NREQ; i++) begin
            rot[i] = req[IDX_W'(ptr + IDX_W'(1) + IDX_W'(i))];
        end
    end

    always_comb begin
        off = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = IDX_W'(i);
            end
        end
    end

    assign valid = |rot;
    assign idx   = IDX_W'(ptr + IDX_W'(1) + off);

endmodule

// File: rtl/rr_decoder_arbiter.sv
// rtl/rr_decoder_arbiter.sv - round-robin owner of a shared 3-to-8 decoder with dead gap and hold timeout
module rr_decoder_arbiter
    import rr_decoder_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NREQ-1:0]  req,
    output logic             gnt_en,
    output logic [IDX_W-1:0] gnt_idx,
    output logic [NREQ-1:0]  gnt,
    output logic             busy,
    output logic             timeout
);

    localparam int HOLD_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);

    arb_state_e       state_q;
    logic             gnt_en_q;
    logic [IDX_W-1:0] gnt_idx_q;
    logic [IDX_W-1:0] ptr_q;
    logic [HOLD_W-1:0] hold_cnt_q;
    logic             timeout_q;

    logic             pick_valid;
    logic [IDX_W-1:0] pick_idx;
    logic             at_limit;
    logic             others_waiting;

    rr_pick8 u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    assign at_limit       = (MAX_HOLD != 0) && (hold_cnt_q == HOLD_LAST);
    assign others_waiting = |(req & ~onehot8(gnt_idx_q));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            gnt_en_q   <= 1'b0;
            gnt_idx_q  <= '0;
            ptr_q      <= IDX_W'(NREQ - 1);
            hold_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (pick_valid) begin
                        state_q    <= ST_GRANT;
                        gnt_en_q   <= 1'b1;
                        gnt_idx_q  <= pick_idx;
                        ptr_q      <= pick_idx;
                        hold_cnt_q <= '0;
                    end
                end
                ST_GRANT: begin
                    // A release on the limit edge wins over the timeout
                    if (!req[gnt_idx_q]) begin
                        gnt_en_q <= 1'b0;
                        state_q  <= ST_GAP;
                    end else if (at_limit && others_waiting) begin
                        gnt_en_q  <= 1'b0;
                        timeout_q <= 1'b1;
                        state_q   <= ST_GAP;
                    end else if (at_limit) begin
                        hold_cnt_q <= '0;
                    end else if (MAX_HOLD != 0) begin
                        hold_cnt_q <= hold_cnt_q + HOLD_W'(1);
                    end
                end
                ST_GAP: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q  <= ST_IDLE;
                    gnt_en_q <= 1'b0;
                end
            endcase
        end
    end

    assign gnt_en  = gnt_en_q;
    assign gnt_idx = gnt_idx_q;
    assign gnt     = gnt_en_q ? onehot8(gnt_idx_q) : '0;
    assign busy    = (state_q == ST_GRANT) || (state_q == ST_GAP);
    assign timeout = timeout_q;

endmodule

// File: tb/tb_rr_decoder_arbiter.sv
// tb/tb_rr_decoder_arbiter.sv - self-checking bench for rr_decoder_arbiter with a behavioural model
module tb_rr_decoder_arbiter;

    localparam int MH = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req;
    logic       gnt_en;
    logic [2:0] gnt_idx;
    logic [7:0] gnt;
    logic       busy;
    logic       timeout;

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    // Reference model: who owns the decoder, and for how many cycles
    int m_owner;
    int m_last;
    int m_ptr;
    int m_age;
    bit m_gap;
    bit m_to;

    always #5 clk = ~clk;

    rr_decoder_arbiter #(.MAX_HOLD(MH)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .gnt_en  (gnt_en),
        .gnt_idx (gnt_idx),
        .gnt     (gnt),
        .busy    (busy),
        .timeout (timeout)
    );

    task automatic model_reset();
        m_owner = -1;
        m_last  = 0;
        m_ptr   = 7;
        m_age   = 0;
        m_gap   = 1'b0;
        m_to    = 1'b0;
    endtask

    task automatic model_step(input logic [7:0] r);
        m_to = 1'b0;
        if (m_owner >= 0) begin
            m_age++;
            if (!r[m_owner]) begin
                m_owner = -1;
                m_gap   = 1'b1;
            end else if ((m_age % MH) == 0 && (r & ~(8'd1 << m_owner)) != 8'd0) begin
                m_owner = -1;
                m_gap   = 1'b1;
                m_to    = 1'b1;
            end
        end else if (m_gap) begin
            m_gap = 1'b0;
        end else if (r != 8'd0) begin
            int p;
            p = -1;
            for (int k = 1; k <= 8; k++) begin
                if (p < 0 && r[(m_ptr + k) % 8]) p = (m_ptr + k) % 8;
            end
            m_owner = p;
            m_last  = p;
            m_ptr   = p;
            m_age   = 0;
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_reset();
        end else begin
            model_step(req);
            #1;
            if (mon_en) begin
                logic       e_en;
                logic [2:0] e_idx;
                logic [7:0] e_gnt;
                logic       e_busy;
                e_en   = (m_owner >= 0);
                e_idx  = 3'(m_last);
                e_gnt  = e_en ? (8'd1 << m_owner) : 8'd0;
                e_busy = e_en || m_gap;
                checks++;
                if (gnt_en !== e_en || gnt_idx !== e_idx || gnt !== e_gnt ||
                    busy !== e_busy || timeout !== m_to) begin
                    errors++;
                    $display("FAIL model t=%0t en=%b idx=%0d gnt=%h busy=%b to=%b expected en=%b idx=%0d gnt=%h busy=%b to=%b",
                             $time, gnt_en, gnt_idx, gnt, busy, timeout, e_en, e_idx, e_gnt, e_busy, m_to);
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req   = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req   = 8'h00;
        repeat (2) @(negedge clk);
        checks++;
        if (gnt_en !== 1'b0 || gnt_idx !== 3'd0 || gnt !== 8'h00 || busy !== 1'b0 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL reset en=%b idx=%0d gnt=%h busy=%b to=%b expected all zero", gnt_en, gnt_idx, gnt, busy, timeout);
        end
        rst_n  = 1'b1;
        mon_en = 1'b1;
    endtask

    task automatic test_single_grant();
        do_reset();
        req = 8'h04;
        @(negedge clk);
        checks++;
        if (gnt_en !== 1'b1 || gnt_idx !== 3'd2 || gnt !== 8'h04 || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_grant en=%b idx=%0d gnt=%h busy=%b expected 1 2 04 1", gnt_en, gnt_idx, gnt, busy);
        end
        req = 8'h00;
        @(negedge clk);
        checks++;
        if (gnt_en !== 1'b0 || gnt !== 8'h00 || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_gap en=%b gnt=%h busy=%b expected 0 00 1", gnt_en, gnt, busy);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL single_idle busy=%b expected 0", busy);
        end
    endtask

    task automatic test_round_robin();
        int n    = 0;
        int vis  = 0;
        bit prev_en = 1'b0;
        logic [2:0] prev_idx = 3'd0;
        bit bad  = 1'b0;
        do_reset();
        req = 8'hFF;
        for (int cyc = 0; cyc < 200 && n < 9; cyc++) begin
            @(negedge clk);
            if ($countones(gnt) > 1) bad = 1'b1;
            if (gnt_en && prev_en && gnt_idx != prev_idx) bad = 1'b1;
            if (gnt_en && !prev_en) begin
                checks++;
                if (gnt_idx !== 3'(n % 8)) begin
                    errors++;
                    $display("FAIL rr_order grant %0d got %0d expected %0d", n, gnt_idx, n % 8);
                end
                n++;
                vis = 0;
            end
            vis      = gnt_en ? vis + 1 : 0;
            req      = (vis == 3) ? (8'hFF & ~(8'd1 << gnt_idx)) : 8'hFF;
            prev_en  = gnt_en;
            prev_idx = gnt_idx;
        end
        checks++;
        if (n != 9 || bad) begin
            errors++;
            $display("FAIL rr_handoff grants=%0d overlap=%b expected 9 grants and no overlap", n, bad);
        end
        req = 8'h00;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_wrap();
        int w = 0;
        do_reset();
        req = 8'h80;
        @(negedge clk);
        checks++;
        if (gnt_en !== 1'b1 || gnt_idx !== 3'd7) begin
            errors++;
            $display("FAIL wrap_first en=%b idx=%0d expected 1 7", gnt_en, gnt_idx);
        end
        req = 8'h00;
        @(negedge clk);
        while (busy && w < 10) begin
            @(negedge clk);
            w++;
        end
        req = 8'h81;
        @(negedge clk);
        checks++;
        if (gnt_en !== 1'b1 || gnt_idx !== 3'd0) begin
            errors++;
            $display("FAIL wrap en=%b idx=%0d expected 1 0", gnt_en, gnt_idx);
        end
        req = 8'h00;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_timeout();
        int cnt3 = 1;
        int to_seen = 0;
        bit got5 = 1'b0;
        bit lost = 1'b0;
        do_reset();
        req = 8'h08;
        @(negedge clk);
        checks++;
        if (gnt_en !== 1'b1 || gnt_idx !== 3'd3) begin
            errors++;
            $display("FAIL timeout_grant en=%b idx=%0d expected 1 3", gnt_en, gnt_idx);
        end
        req = 8'h28;
        for (int c = 0; c < 20 && !got5; c++) begin
            @(negedge clk);
            if (gnt_en && gnt_idx == 3'd3) cnt3++;
            if (timeout) to_seen++;
            if (gnt_en && gnt_idx == 3'd5) got5 = 1'b1;
        end
        checks++;
        if (cnt3 != MH || to_seen != 1 || !got5) begin
            errors++;
            $display("FAIL timeout_revoke held=%0d pulses=%0d next5=%b expected %0d 1 1", cnt3, to_seen, got5, MH);
        end
        do_reset();
        req = 8'h08;
        to_seen = 0;
        for (int c = 0; c < 3 * MH + 1; c++) begin
            @(negedge clk);
            if (timeout) to_seen++;
            if (!(gnt_en && gnt_idx == 3'd3)) lost = 1'b1;
        end
        checks++;
        if (to_seen != 0 || lost) begin
            errors++;
            $display("FAIL timeout_alone pulses=%0d lost=%b expected 0 0", to_seen, lost);
        end
        req = 8'h00;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_release_on_limit();
        do_reset();
        req = 8'h28;
        repeat (MH) @(negedge clk);
        checks++;
        if (gnt_en !== 1'b1 || gnt_idx !== 3'd3) begin
            errors++;
            $display("FAIL limit_hold en=%b idx=%0d expected 1 3", gnt_en, gnt_idx);
        end
        req = 8'h20;
        @(negedge clk);
        checks++;
        if (gnt_en !== 1'b0 || timeout !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL limit_release en=%b to=%b busy=%b expected 0 0 1", gnt_en, timeout, busy);
        end
        req = 8'h00;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_async_reset();
        do_reset();
        req = 8'h40;
        @(negedge clk);
        checks++;
        if (gnt_en !== 1'b1 || gnt_idx !== 3'd6) begin
            errors++;
            $display("FAIL areset_grant en=%b idx=%0d expected 1 6", gnt_en, gnt_idx);
        end
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (gnt_en !== 1'b0 || gnt !== 8'h00 || busy !== 1'b0 || gnt_idx !== 3'd0) begin
            errors++;
            $display("FAIL areset_async en=%b gnt=%h busy=%b idx=%0d expected 0 00 0 0", gnt_en, gnt, busy, gnt_idx);
        end
        @(negedge clk);
        rst_n = 1'b1;
        req   = 8'h41;
        @(negedge clk);
        checks++;
        if (gnt_en !== 1'b1 || gnt_idx !== 3'd0) begin
            errors++;
            $display("FAIL areset_ptr en=%b idx=%0d expected 1 0", gnt_en, gnt_idx);
        end
        req = 8'h00;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_random();
        do_reset();
        req = 8'($urandom);
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            req = req ^ 8'($urandom & $urandom & $urandom);
        end
        req = 8'h00;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single_grant();
        test_round_robin();
        test_wrap();
        test_timeout();
        test_release_on_limit();
        test_async_reset();
        test_random();
        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete in time");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/rr_decoder_arbiter.md
Name: rr_decoder_arbiter

Overview:
- Round-robin arbiter sharing one 3-to-8 decoder (inputs en, a[2:0]; output op[7:0]) among 8 requesters.
- Converts per-requester request/release into a registered owner index plus decoder enable, and mirrors the decoder's one-hot select.
- Sits directly in front of decoder3; its gnt_idx/gnt_en drive decoder3 a/en.
- Enforces a one-cycle dead gap between owners and an optional hold timeout.

Parameters:
- NREQ, 8, number of requesters. Fixed at 8; the decoder width is 3 bits.
- MAX_HOLD, 16, maximum consecutive cycles one owner holds the grant while others wait. 0 disables the timeout.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req  in  8  request per requester; held high for the whole use, dropped to release
- gnt_en  out  1  decoder enable; high while an owner holds the grant
- gnt_idx  out  3  owner index; drives decoder address a
- gnt  out  8  one-hot grant, equal to (gnt_en ? 1<<gnt_idx : 0)
- busy  out  1  high in GRANT or GAP
- timeout  out  1  one-cycle pulse when a grant is revoked by MAX_HOLD

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, gnt_en=0, gnt_idx=0, gnt=0, busy=0, timeout=0.
  - ptr=7, so requester 0 has first priority.
  - hold_cnt=0.
- States: IDLE, GRANT, GAP.
- IDLE:
  - If req!=0, pick the first set bit searching ptr+1, ptr+2, ... mod 8.
  - Register gnt_idx=pick, gnt_en=1, ptr=pick, hold_cnt=0, and go to GRANT.
  - Latency: req sampled at edge N gives the grant visible after edge N (one registered stage). No grant if req==0.
- GRANT:
  - gnt_idx is stable and only the owner's req is observed.
  - If req[gnt_idx]==0 at an edge: gnt_en=0, go to GAP.
  - Else if MAX_HOLD!=0, hold_cnt==MAX_HOLD-1, and (req & ~(1<<gnt_idx))!=0:
    - gnt_en=0, timeout=1 for one cycle, go to GAP.
    - The revoked owner must re-request; its req staying high counts as a new request at the next arbitration.
  - Else if MAX_HOLD!=0 and hold_cnt==MAX_HOLD-1 with no other requester: hold_cnt wraps to 0 and the owner keeps the grant (no timeout pulse).
  - Else hold_cnt increments. Width is clog2(MAX_HOLD+1), and it never overflows.
- GAP:
  - Exactly one cycle with gnt_en=0 and gnt=0. gnt_idx keeps its last value.
  - Then go to IDLE, which re-arbitrates in that same cycle.
  - Worst-case owner-to-owner turnaround is therefore 2 dead cycles (GAP plus IDLE).
- Fairness: ptr only updates at grant. After owner k, requester k+1 mod 8 has top priority. Wrap 7→0 is mandatory.
- Simultaneous events:
  - Owner drops req in the same cycle as a timeout: this is treated as a release, so timeout stays 0.
  - New reqs arriving during GRANT/GAP wait; there is no pre-emption.
  - Reqs toggling in IDLE are sampled only at the edge.
- Reset mid-GRANT: outputs go to reset values immediately (async) and ptr returns to 7.
- busy=1 in GRANT and GAP.
- gnt is combinational from registered gnt_en/gnt_idx, so it is glitch-free relative to the decoder.

Decomposition:
- Shared package:
  - state enum (IDLE=2'd0, GRANT=2'd1, GAP=2'd2)
  - NREQ=8, IDX_W=3
  - the one-hot helper constant/function
- One sub-module, rr_pick8: combinational rotating priority picker.
  - Inputs: req[7:0], ptr[2:0].
  - Outputs: valid, idx[2:0].
  - Implemented as a rotate → fixed-priority → un-rotate.
- A decoder3 instance is not inside this block; the integrating top connects gnt_en/gnt_idx to it.

Test Plan:
- Reset then req=8'h04 → one edge later gnt_en=1, gnt_idx=2, gnt=8'h04, busy=1. Drop req → next cycle gnt=0 (GAP), then IDLE, busy=0.
- req=8'hFF held (each owner releases after 3 cycles and re-raises) → grant order 0,1,2,...,7,0. Each handoff shows a gnt_en=0 gap ≥1 cycle and never two bits set in gnt.
- After owner 7, req=8'h81 → next grant is 0 (wrap), not 7.
- MAX_HOLD=4, req[3] held, req[5] raised at cycle 1 → gnt_idx=3 for 4 cycles, timeout pulse, GAP, then gnt_idx=5. With req[3] alone → no timeout, grant persists.
- Owner drops req on the same edge the timeout would fire → timeout=0, normal release.
- rst_n pulsed low mid-GRANT (owner 6) → gnt_en, gnt and busy go 0 without waiting for clk. After release, req=8'h41 → grant 0 first (ptr reset to 7).
